// File: rtl/risc_muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
package risc_muldiv_pkg;

  localparam int DEF_WIDTH = 8;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/risc_addsub.sv
// W-bit adder/subtractor with carry out; subtract is a + ~b + 1, so cout=1 means no borrow.
module risc_addsub #(
  parameter int W = 9
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  logic [W-1:0] b_eff;

  assign b_eff = sub_i ? ~b_i : b_i;
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + {{W{1'b0}}, sub_i};

endmodule

// File: rtl/risc_muldiv_seq.sv
// Sequential shift-add multiplier / restoring divider, one bit per cycle,
// with a sign-fix cycle and single-cycle done pulse.
module risc_muldiv_seq
  import risc_muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic             sgn,
  input  logic             abort,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic             div_by_0,
  output logic             ovf,
  output logic             zero
);

  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] bop_q, bop_d;
  logic             op_q, op_d;
  logic             neg_q, neg_d;
  logic             nega_q, nega_d;
  logic             ovfp_q, ovfp_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     as_a, as_b, as_sum;
  logic               as_sub, as_cout;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign a_mag = (sgn && a_in[WIDTH-1]) ? -a_in : a_in;
  assign b_mag = (sgn && b_in[WIDTH-1]) ? -b_in : b_in;

  // hi_q is the running partial product (mul) or partial remainder (div);
  // lo_q holds the multiplier bits or the dividend/quotient shift register.
  assign as_sub = (op_q == OP_DIV);
  assign as_a   = (op_q == OP_DIV) ? {hi_q, lo_q[WIDTH-1]} : {1'b0, hi_q};
  assign as_b   = {1'b0, ((op_q == OP_DIV) || lo_q[0]) ? bop_q : '0};

  risc_addsub #(.W(WIDTH + 1)) u_addsub (
    .a_i   (as_a),
    .b_i   (as_b),
    .sub_i (as_sub),
    .sum_o (as_sum),
    .cout_o(as_cout)
  );

  assign prod     = {hi_q, lo_q};
  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = neg_q ? -lo_q : lo_q;
  assign rem_fix  = nega_q ? -hi_q : hi_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    bop_d    = bop_q;
    op_d     = op_q;
    neg_d    = neg_q;
    nega_d   = nega_q;
    ovfp_d   = ovfp_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    dbz_d    = dbz_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          op_d   = op;
          bop_d  = b_mag;
          lo_d   = a_mag;
          hi_d   = '0;
          cnt_d  = '0;
          neg_d  = sgn && (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
          nega_d = sgn && a_in[WIDTH-1];
          ovfp_d = sgn && (op == OP_DIV) && (a_in == MIN_VAL) && (b_in == '1);
          if ((op == OP_DIV) && (b_in == '0)) begin
            // Divide by zero skips the datapath entirely.
            state_d  = ST_DONE;
            res_lo_d = '1;
            res_hi_d = a_in;
            dbz_d    = 1'b1;
            ovf_d    = 1'b0;
            zero_d   = 1'b0;
          end else begin
            state_d = ST_CALC;
          end
        end
      end

      ST_CALC: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          if (op_q == OP_DIV) begin
            if (as_cout) begin
              hi_d = as_sum[WIDTH-1:0];
              lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
              hi_d = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
              lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            hi_d = as_sum[WIDTH:1];
            lo_d = {as_sum[0], lo_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == LAST_IT) begin
            state_d = ST_FIX;
          end
        end
      end

      ST_FIX: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
          dbz_d   = 1'b0;
          ovf_d   = ovfp_q;
          if (op_q == OP_MUL) begin
            res_lo_d = prod_fix[WIDTH-1:0];
            res_hi_d = prod_fix[2*WIDTH-1:WIDTH];
            zero_d   = (prod_fix == '0);
          end else begin
            res_lo_d = quo_fix;
            res_hi_d = rem_fix;
            zero_d   = (quo_fix == '0);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      bop_q    <= '0;
      op_q     <= 1'b0;
      neg_q    <= 1'b0;
      nega_q   <= 1'b0;
      ovfp_q   <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      bop_q    <= bop_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      nega_q   <= nega_d;
      ovfp_q   <= ovfp_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      dbz_q    <= dbz_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign busy     = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign done     = (state_q == ST_DONE);
  assign res_lo   = res_lo_q;
  assign res_hi   = res_hi_q;
  assign div_by_0 = dbz_q;
  assign ovf      = ovf_q;
  assign zero     = zero_q;

endmodule
